// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the RV32I multi-cycle control FSM.
//   aluop_t  : 4-bit ALU op code consumed by the ALU
//   state_t  : control FSM states
//   wb_sel_t : register-file write-back source select
//   OP_*     : RV32I major opcodes handled by the decoder
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } aluop_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // funct3 -> ALU op for the register/immediate ALU groups (non-alternate forms).
    function automatic aluop_t alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_aluop_decode.sv
// aluop_decode: combinational instruction-field decoder.
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]
//   funct7  in  7  instr[31:25]
//   aluop   out 4  ALU op for this instruction
//   illegal out 1  opcode/funct combination not supported
// Build option: ALU_SRA_EN enables SRA/SRAI; without it both encodings
// are flagged illegal and ALU_SRA is never produced.
module aluop_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output aluop_t     aluop,
    output logic       illegal
);

`ifdef ALU_SRA_EN
    localparam logic SRA_OK = 1'b1;
`else
    localparam logic SRA_OK = 1'b0;
`endif

    always_comb begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_REG: begin
                if (funct7 == 7'b0000000)
                    aluop = alu_from_f3(funct3);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    aluop = ALU_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101 && SRA_OK)
                    aluop = ALU_SRA;
                else
                    illegal = 1'b1;
            end
            OP_IMM: begin
                // Only the shifts carry funct7; everything else is an immediate.
                case (funct3)
                    3'b001: begin
                        if (funct7 == 7'b0000000) aluop = ALU_SLL;
                        else                      illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)                aluop = ALU_SRL;
                        else if (funct7 == 7'b0100000 && SRA_OK) aluop = ALU_SRA;
                        else                                     illegal = 1'b1;
                    end
                    default: aluop = alu_from_f3(funct3);
                endcase
            end
            OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OP_STORE:  illegal = (funct3 > 3'b010);
            OP_BRANCH: begin
                aluop   = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JALR:   illegal = (funct3 != 3'b000);
            OP_JAL:    aluop = ALU_ADD;
            OP_AUIPC:  aluop = ALU_ADD;
            OP_LUI:    aluop = ALU_PASS_B;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control FSM (IDLE/DECODE/EXEC/MEM/WB/TRAP).
// All outputs are registered and decoded from the next state.
//   clk, rst_n          clock, async active-low reset
//   instr, instr_valid  instruction handshake in; instr_ready out (IDLE only)
//   br_taken            branch result, sampled in EXEC
//   mem_ready           data-memory done, sampled in MEM
//   aluop, sel_a, sel_b ALU control, valid EXEC..WB
//   mem_rd, mem_wr      memory strobes, held through MEM
//   rf_en, wb_sel       register write enable / source (WB)
//   pc_en, pc_sel       PC update (WB or TRAP) and source
//   illegal             one-cycle pulse in TRAP
// Parameter MEM_TIMEOUT: MEM cycles before trapping, 0 = wait forever.
// Build option ALU_SRA_EN (see aluop_decode).
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic [3:0]  aluop,
    output logic        sel_a,
    output logic        sel_b,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        rf_en,
    output logic [1:0]  wb_sel,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        illegal
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [31:0] instr_q;
    logic [CW-1:0] mem_cnt;

    // Per-instruction class, latched in DECODE so later states need no re-decode.
    logic    is_ld, is_st, is_br, is_jmp, rf_we;
    wb_sel_t wb_q;

    aluop_t dec_op;
    logic   dec_ill;
    logic [6:0] opc;
    logic   mem_to;
    logic   unused_bits;

    assign opc         = instr_q[6:0];
    assign unused_bits = ^{instr_q[24:15], instr_q[11:7]};
    // Last permitted MEM cycle; mem_ready still wins if it arrives here.
    assign mem_to      = (MEM_TIMEOUT != 0) && (mem_cnt == TO_LAST);

    aluop_decode u_dec (
        .opcode  (instr_q[6:0]),
        .funct3  (instr_q[14:12]),
        .funct7  (instr_q[31:25]),
        .aluop   (dec_op),
        .illegal (dec_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            mem_cnt     <= '0;
            is_ld       <= 1'b0;
            is_st       <= 1'b0;
            is_br       <= 1'b0;
            is_jmp      <= 1'b0;
            rf_we       <= 1'b0;
            wb_q        <= WB_ALU;
            instr_ready <= 1'b0;
            aluop       <= '0;
            sel_a       <= 1'b0;
            sel_b       <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            rf_en       <= 1'b0;
            wb_sel      <= '0;
            pc_en       <= 1'b0;
            pc_sel      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            // Outputs default low; each transition re-asserts what its target state shows.
            instr_ready <= 1'b0;
            aluop       <= '0;
            sel_a       <= 1'b0;
            sel_b       <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            rf_en       <= 1'b0;
            wb_sel      <= '0;
            pc_en       <= 1'b0;
            pc_sel      <= 1'b0;
            illegal     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q <= instr;
                        state   <= S_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_ill) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                        pc_en   <= 1'b1;
                    end else begin
                        state  <= S_EXEC;
                        aluop  <= dec_op;
                        sel_a  <= (opc == OP_JAL) || (opc == OP_AUIPC);
                        sel_b  <= (opc != OP_REG) && (opc != OP_BRANCH);
                        is_ld  <= (opc == OP_LOAD);
                        is_st  <= (opc == OP_STORE);
                        is_br  <= (opc == OP_BRANCH);
                        is_jmp <= (opc == OP_JAL) || (opc == OP_JALR);
                        rf_we  <= (opc != OP_STORE) && (opc != OP_BRANCH);
                        wb_q   <= (opc == OP_LOAD) ? WB_MEM :
                                  ((opc == OP_JAL) || (opc == OP_JALR)) ? WB_PC4 : WB_ALU;
                    end
                end
                S_EXEC: begin
                    aluop <= aluop;
                    sel_a <= sel_a;
                    sel_b <= sel_b;
                    if (is_ld || is_st) begin
                        state   <= S_MEM;
                        mem_rd  <= is_ld;
                        mem_wr  <= is_st;
                        mem_cnt <= '0;
                    end else begin
                        state  <= S_WB;
                        rf_en  <= rf_we;
                        wb_sel <= wb_q;
                        pc_en  <= 1'b1;
                        pc_sel <= is_jmp || (is_br && br_taken);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state  <= S_WB;
                        aluop  <= aluop;
                        sel_a  <= sel_a;
                        sel_b  <= sel_b;
                        rf_en  <= is_ld;
                        wb_sel <= wb_q;
                        pc_en  <= 1'b1;
                    end else if (mem_to) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                        pc_en   <= 1'b1;
                    end else begin
                        aluop   <= aluop;
                        sel_a   <= sel_a;
                        sel_b   <= sel_b;
                        mem_rd  <= mem_rd;
                        mem_wr  <= mem_wr;
                        mem_cnt <= mem_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
                S_TRAP: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the driver pushes the expected retirement
// record for each instruction; the monitor pops and compares whenever pc_en fires.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  aluop;
    logic        sel_a, sel_b, mem_rd, mem_wr, rf_en, pc_en, pc_sel, illegal;
    logic [1:0]  wb_sel;

    mc_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .br_taken(br_taken), .mem_ready(mem_ready),
        .aluop(aluop), .sel_a(sel_a), .sel_b(sel_b), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .rf_en(rf_en), .wb_sel(wb_sel), .pc_en(pc_en),
        .pc_sel(pc_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] op;
        logic       sa, sb, rf;
        logic [1:0] wb;
        logic       ps, ill;
        int         lat, nrd, nwr;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s id=%0d got=%0d want=%0d", nm, id, act, want);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [3:0] op, input logic sa, input logic sb,
                                input logic rf, input logic [1:0] wb, input logic ps, input logic ill,
                                input int lat, input int nrd, input int nwr);
        exp_t e;
        e.id = id; e.op = op; e.sa = sa; e.sb = sb; e.rf = rf; e.wb = wb;
        e.ps = ps; e.ill = ill; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int hs_cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    bit chk_rdy = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_rd = 0; n_wr = 0; chk_rdy = 1'b0;
        end else begin
            if (chk_rdy) begin
                chk("ready_after_retire", -1, int'(instr_ready), 1);
                chk_rdy = 1'b0;
            end
            if (instr_valid && instr_ready) hs_cyc = cyc;
            if (mem_rd) n_rd++;
            if (mem_wr) n_wr++;
            if (pc_en) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pc_en", -1, 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("aluop",   e.id, int'(aluop),   int'(e.op));
                    chk("sel_a",   e.id, int'(sel_a),   int'(e.sa));
                    chk("sel_b",   e.id, int'(sel_b),   int'(e.sb));
                    chk("rf_en",   e.id, int'(rf_en),   int'(e.rf));
                    chk("wb_sel",  e.id, int'(wb_sel),  int'(e.wb));
                    chk("pc_sel",  e.id, int'(pc_sel),  int'(e.ps));
                    chk("illegal", e.id, int'(illegal), int'(e.ill));
                    chk("strobes_at_retire", e.id, int'(mem_rd | mem_wr), 0);
                    chk("latency", e.id, cyc - hs_cyc, e.lat);
                    chk("rd_cycles", e.id, n_rd, e.nrd);
                    chk("wr_cycles", e.id, n_wr, e.nwr);
                end
                n_rd = 0; n_wr = 0; chk_rdy = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready(input int id);
        int n = 0;
        while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!instr_ready) chk("wait_ready_timeout", id, 0, 1);
    endtask

    // rdy_at: MEM cycle (1-based) on which mem_ready is raised, 0 = never.
    // pre: hold mem_ready high before MEM (must be ignored).
    // noise: keep instr_valid high with a junk word during DECODE (must be ignored).
    task automatic run(input logic [31:0] ins, input exp_t e, input logic brt,
                       input int rdy_at, input bit pre, input bit noise);
        int k = 0;
        int n = 0;
        wait_ready(e.id);
        instr = ins; instr_valid = 1'b1; br_taken = brt; mem_ready = pre;
        sb_q.push_back(e);
        @(posedge clk); #1;
        if (noise) instr = 32'hFFFF_FFFF;
        else       instr_valid = 1'b0;
        while (!instr_ready && n < 100) begin
            if (n >= 1) instr_valid = 1'b0;
            if (mem_rd || mem_wr) begin
                k++;
                mem_ready = (k == rdy_at);
            end else if (k > 0) begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        if (!instr_ready) chk("retire_timeout", e.id, 0, 1);
        instr_valid = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        chk("reset_outputs", 0,
            int'({instr_ready, aluop, sel_a, sel_b, mem_rd, mem_wr, rf_en, wb_sel, pc_en, pc_sel, illegal}), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 0, int'(instr_ready), 1);

        // add x3,x1,x2
        run(32'h002081B3, mk(1, 4'b0000, 0, 0, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 1);
        // sub x3,x1,x2
        run(32'h402081B3, mk(2, 4'b0001, 0, 0, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        // or x3,x1,x2
        run(32'h0020E1B3, mk(3, 4'b1000, 0, 0, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        // andi x5,x6,0xff
        run(32'h0FF37293, mk(4, 4'b1001, 0, 1, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        // lw x5,4(x1), mem_ready on 3rd MEM cycle, early mem_ready ignored
        run(32'h0040A283, mk(5, 4'b0000, 0, 1, 1, 2'd1, 0, 0, 6, 3, 0), 0, 3, 1, 0);
        // sw x2,8(x1), never ready: 16 MEM cycles then trap
        run(32'h0020A423, mk(6, 4'b0000, 0, 0, 0, 2'd0, 0, 1, 19, 0, 16), 0, 0, 0, 0);
        // sw again, ready on the timeout cycle: WB wins, counter restarted
        run(32'h0020A423, mk(7, 4'b0000, 0, 1, 0, 2'd0, 0, 0, 19, 0, 16), 0, 16, 0, 0);
        // beq taken / not taken
        run(32'h00208463, mk(8, 4'b0001, 0, 0, 0, 2'd0, 1, 0, 3, 0, 0), 1, 0, 0, 0);
        run(32'h00208463, mk(9, 4'b0001, 0, 0, 0, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        // jal x1,+16 ; jalr x1,0(x2)
        run(32'h010000EF, mk(10, 4'b0000, 1, 1, 1, 2'd2, 1, 0, 3, 0, 0), 0, 0, 0, 0);
        run(32'h000100E7, mk(11, 4'b0000, 0, 1, 1, 2'd2, 1, 0, 3, 0, 0), 0, 0, 0, 1);
        // lui x4,0x12345 ; auipc x4,1
        run(32'h12345237, mk(12, 4'b1010, 0, 1, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        run(32'h00001217, mk(13, 4'b0000, 1, 1, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        // unknown opcode traps from DECODE
        run(32'hFFFFFFFF, mk(14, 4'b0000, 0, 0, 0, 2'd0, 0, 1, 2, 0, 0), 0, 0, 0, 0);
`ifdef ALU_SRA_EN
        run(32'h407352B3, mk(15, 4'b0111, 0, 0, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        run(32'h40335293, mk(16, 4'b0111, 0, 1, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
`else
        run(32'h407352B3, mk(15, 4'b0000, 0, 0, 0, 2'd0, 0, 1, 2, 0, 0), 0, 0, 0, 0);
        run(32'h40335293, mk(16, 4'b0000, 0, 0, 0, 2'd0, 0, 1, 2, 0, 0), 0, 0, 0, 0);
`endif

        // async reset during MEM of a load: in-flight lw is discarded
        wait_ready(17);
        instr = 32'h0040A283; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n = 0;
        while (!mem_rd && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst_mem_entry", 17, int'(mem_rd), 1);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_rd_drop", 17, int'(mem_rd), 0);
        chk("rst_all_zero", 17,
            int'({instr_ready, aluop, sel_a, sel_b, mem_rd, mem_wr, rf_en, wb_sel, pc_en, pc_sel, illegal}), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst2", 17, int'(instr_ready), 1);

        // normal traffic after reset
        run(32'h002081B3, mk(18, 4'b0000, 0, 0, 1, 2'd0, 0, 0, 3, 0, 0), 0, 0, 0, 0);
        run(32'h0040A283, mk(19, 4'b0000, 0, 1, 1, 2'd1, 0, 0, 4, 1, 0), 0, 1, 0, 0);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 0, sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
